// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer and the control decoder:
// opcode field width, opcode values, fetch FSM encoding and PC step.
package instr_fetch_unit_pkg;

    localparam int OPCODE_W = 6;
    localparam int PC_STEP  = 4;

    localparam logic [OPCODE_W-1:0] OP_J    = 6'b010101;
    localparam logic [OPCODE_W-1:0] OP_JR   = 6'b010110;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 6'b010111;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_BNEQ = 6'b001011;
    localparam logic [OPCODE_W-1:0] OP_BGEZ = 6'b001100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

    // True for opcodes that may redirect the PC once resolved downstream.
    function automatic logic is_flow_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_J) || (op == OP_JR) || (op == OP_JAL) ||
               (op == OP_BEQ) || (op == OP_BNEQ) || (op == OP_BGEZ);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory req/ack bus and the decode valid/ready bus.
// master = fetch unit side, slave = memory/decode side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import instr_fetch_unit_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [DATA_W-1:0]   imem_rdata;

    logic                instr_valid;
    logic                instr_ready;
    logic [DATA_W-1:0]   instr;
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   pc_out;
    logic [ADDR_W-1:0]   pc_plus4;

    logic                jump;
    logic [ADDR_W-1:0]   jump_target;
    logic                branch_taken;
    logic [ADDR_W-1:0]   branch_target;

    logic [31:0]         retired_cnt;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, opcode, pc_out, pc_plus4, retired_cnt,
        input  instr_ready, jump, jump_target, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, opcode, pc_out, pc_plus4, retired_cnt,
        output instr_ready, jump, jump_target, branch_taken, branch_target
    );

endinterface

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC selection: jump beats branch beats sequential step.
// Pure combinational; all arithmetic wraps modulo 2^ADDR_W.
module instr_fetch_unit_pc_next_sel
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_target,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [ADDR_W-1:0] o_pc_plus4,
    output logic [ADDR_W-1:0] o_next_pc
);

    logic [ADDR_W-1:0] w_pc_plus4;

    assign w_pc_plus4 = i_pc + ADDR_W'(PC_STEP);
    assign o_pc_plus4 = w_pc_plus4;

    always_comb begin
        o_next_pc = w_pc_plus4;
        if (i_jump) begin
            o_next_pc = i_jump_target;
        end else if (i_branch_taken) begin
            o_next_pc = i_branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: holds the PC, fetches one word at a time over
// req/ack and hands it to decode over valid/ready, then advances or redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_req;
    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [31:0]       r_retired_cnt;

    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_pc_plus4;

    instr_fetch_unit_pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_sel (
        .i_pc            (r_pc),
        .i_jump          (bus.jump),
        .i_jump_target   (bus.jump_target),
        .i_branch_taken  (bus.branch_taken),
        .i_branch_target (bus.branch_target),
        .o_pc_plus4      (w_pc_plus4),
        .o_next_pc       (w_next_pc)
    );

    // r_pc doubles as the request address and the presented-instruction PC,
    // since the PC only moves on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_req         <= 1'b0;
            r_valid       <= 1'b0;
            r_instr       <= '0;
            r_retired_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req   <= 1'b1;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        r_instr <= bus.imem_rdata;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (bus.instr_ready) begin
                        r_valid       <= 1'b0;
                        r_req         <= 1'b1;
                        r_pc          <= w_next_pc;
                        r_retired_cnt <= r_retired_cnt + 32'd1;
                        r_state       <= S_REQ;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_valid;
    assign bus.instr       = r_instr;
    assign bus.opcode      = r_instr[DATA_W-1 -: OPCODE_W];
    assign bus.pc_out      = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: memory/decode driver plus
// an independent monitor checking each presented instruction against a PC model.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_w ();

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk (clk), .rst (rst), .bus (bus.master)
    );

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk (clk), .rst (rst), .bus (bus_w.master)
    );

    // Wrap instance: zero-wait memory, always-ready decode, no redirects.
    assign bus_w.imem_ack      = bus_w.imem_req;
    assign bus_w.imem_rdata    = 32'hDEAD_BEEF;
    assign bus_w.instr_ready   = 1'b1;
    assign bus_w.jump          = 1'b0;
    assign bus_w.branch_taken  = 1'b0;
    assign bus_w.jump_target   = 32'h0;
    assign bus_w.branch_target = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_pc;
    logic [31:0] model_cnt;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0000;
        if (a == 32'h4) return 32'h2001_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per new presentation, checks stability while stalled.
    initial begin
        exp_t cur;
        bit   have;
        have = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 0;
            end else if (bus.instr_valid) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", {31'b0, bus.instr_valid}, 32'h0);
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1;
                        chk("instr",       bus.instr,       cur.ins);
                        chk("opcode",      {26'b0, bus.opcode}, {26'b0, cur.ins[31:26]});
                        chk("pc_out",      bus.pc_out,      cur.pc);
                        chk("pc_plus4",    bus.pc_plus4,    cur.pc + 32'd4);
                        chk("retired_cnt", bus.retired_cnt, cur.cnt);
                        $display("[TB] txn pc=%h instr=%h cnt=%0d", cur.pc, cur.ins, cur.cnt);
                    end
                end else begin
                    chk("instr_stable", bus.instr,  cur.ins);
                    chk("pc_stable",    bus.pc_out, cur.pc);
                end
                if (bus.instr_ready) have = 0;
            end else begin
                have = 0;
            end
        end
    end

    task automatic noise();
        bus.jump          = 1'($urandom);
        bus.branch_taken  = 1'($urandom);
        bus.jump_target   = $urandom;
        bus.branch_target = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int wait_cyc, input int stall_cyc, input bit expect_now,
                            input bit j, input bit b, input logic [31:0] jt, input logic [31:0] bt);
        exp_t e;
        int   guard;
        guard = 0;
        if (expect_now) chk("req_after_accept", {31'b0, bus.imem_req}, 32'h1);
        while (!bus.imem_req && guard < 20) begin
            bus.instr_ready = 1'($urandom);
            noise();
            tick();
            guard++;
        end
        if (!bus.imem_req) begin
            chk("req_timeout", {31'b0, bus.imem_req}, 32'h1);
            return;
        end
        chk("imem_addr",    bus.imem_addr, model_pc);
        chk("valid_in_req", {31'b0, bus.instr_valid}, 32'h0);
        repeat (wait_cyc) begin
            bus.imem_ack    = 1'b0;
            bus.instr_ready = 1'($urandom);
            noise();
            tick();
            chk("req_hold",  {31'b0, bus.imem_req}, 32'h1);
            chk("addr_hold", bus.imem_addr, model_pc);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = memword(bus.imem_addr);
        e.pc  = model_pc;
        e.ins = memword(model_pc);
        e.cnt = model_cnt;
        exp_q.push_back(e);
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        chk("valid_next", {31'b0, bus.instr_valid}, 32'h1);
        chk("req_drop",   {31'b0, bus.imem_req},    32'h0);
        repeat (stall_cyc) begin
            bus.instr_ready = 1'b0;
            noise();
            tick();
            chk("valid_hold", {31'b0, bus.instr_valid}, 32'h1);
            chk("cnt_hold",   bus.retired_cnt, model_cnt);
        end
        bus.instr_ready   = 1'b1;
        bus.jump          = j;
        bus.branch_taken  = b;
        bus.jump_target   = jt;
        bus.branch_target = bt;
        model_pc  = j ? jt : (b ? bt : model_pc + 32'd4);
        model_cnt = model_cnt + 32'd1;
        tick();
        bus.instr_ready  = 1'b0;
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        chk("cnt_after", bus.retired_cnt, model_cnt);
    endtask

    // Release reset at posedge+1 and check the one-cycle idle before the first request.
    task automatic release_reset();
        rst = 1'b0;
        model_pc  = 32'h0;
        model_cnt = 32'h0;
        exp_q.delete();
        chk("idle_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        chk("first_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("first_addr", bus.imem_addr, 32'h0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req",   {31'b0, bus.imem_req},    32'h0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_instr", bus.instr,                32'h0);
        chk("rst_cnt",   bus.retired_cnt,          32'h0);
        chk("rst_pc",    bus.pc_out,               32'h0);
        chk("rst_op",    {26'b0, bus.opcode},      32'h0);
    endtask

    initial begin
        bit          j;
        bit          b;
        int          r;
        logic [31:0] jt;
        logic [31:0] bt;

        bus.imem_ack = 1'b0;  bus.imem_rdata = 32'h0;  bus.instr_ready = 1'b0;
        bus.jump = 1'b0;  bus.branch_taken = 1'b0;
        bus.jump_target = 32'h0;  bus.branch_target = 32'h0;
        model_pc = 32'h0;  model_cnt = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        chk("wrap_rst_pc", bus_w.pc_out, 32'hFFFF_FFFC);
        rst = 1'b0;
        chk("idle_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        chk("first_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("first_addr", bus.imem_addr, 32'h0);
        chk("wrap_addr0", bus_w.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_valid",  {31'b0, bus_w.instr_valid}, 32'h1);
        chk("wrap_pc_out", bus_w.pc_out,   32'hFFFF_FFFC);
        chk("wrap_plus4",  bus_w.pc_plus4, 32'h0);
        chk("wrap_opcode", {26'b0, bus_w.opcode}, 32'h37);
        chk("addr_hold_noack", bus.imem_addr, 32'h0);
        tick();
        chk("wrap_req1",  {31'b0, bus_w.imem_req}, 32'h1);
        chk("wrap_addr1", bus_w.imem_addr,   32'h0);
        chk("wrap_cnt",   bus_w.retired_cnt, 32'h1);

        // Sequential fetch, branch at 0x8, then wait states/backpressure with jump priority.
        do_fetch(0, 0, 1, 0, 0, 32'h0, 32'h0);
        do_fetch(0, 0, 1, 0, 0, 32'h0, 32'h0);
        do_fetch(0, 0, 1, 0, 1, 32'h0, 32'h40);
        do_fetch(3, 4, 1, 1, 1, 32'h100, 32'h200);
        do_fetch(0, 1, 1, 0, 1, 32'h0, 32'h40);

        // Reset while requesting 0x40; an ack just after release must be ignored.
        chk("pre_rst_addr", bus.imem_addr, 32'h40);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        release_reset();
        bus.imem_ack = 1'b0;
        chk("late_ack_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("late_ack_cnt",   bus.retired_cnt, 32'h0);

        for (int i = 0; i < 120; i++) begin
            r  = int'($urandom_range(0, 5));
            j  = (r == 0);
            b  = (r == 1) || (r == 0 && ($urandom % 2 == 1));
            jt = ($urandom % 4 == 0) ? 32'hFFFF_FFFC : $urandom;
            bt = $urandom;
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1, j, b, jt, bt);
        end

        // Asynchronous reset while an instruction is presented.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = memword(bus.imem_addr);
        @(posedge clk);
        #3;
        bus.imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        chk("rst_plus4", bus.pc_plus4, 32'h4);
        tick();
        release_reset();

        for (int i = 0; i < 20; i++) begin
            do_fetch(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1,
                     1'($urandom), 1'($urandom), $urandom, $urandom);
        end
        chk("final_cnt", bus.retired_cnt, model_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
